usb_tx_ctrl: RTL and testbench



---
 rtl/usb_tx_pkg.sv | 20 ++
 rtl/usb_bit_timer.sv | 33 +++
 rtl/usb_tx_ctrl.sv | 161 ++++++++++++++++
 tb/tb_usb_tx_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
//   tx_state_t           : sequencer states
//   SYNC_BYTE            : SYNC pattern, sent LSB-first (seven 0s then a 1)
//   DEFAULT_CLKS_PER_BIT : clocks per USB bit period
//   DEFAULT_STUFF_LIMIT  : run of transmitted ones that forces a stuffed zero
package usb_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StStuff,
        StEopWait
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE            = 8'h80;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 8;
    localparam int unsigned DEFAULT_STUFF_LIMIT  = 6;

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period counter for the USB transmit sequencer.
//   clk, n_rst : clock, asynchronous active-low reset
//   enable     : count 0..CLKS_PER_BIT-1 and wrap
//   clear      : force the count to 0 (wins over enable)
//   rollover   : high during the last clock of each period while enabled
module usb_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    output logic rollover
);

    localparam int unsigned    CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= (count_q == CntMax) ? '0 : count_q + CntW'(1);
        end
    end

    assign rollover = enable && (count_q == CntMax);

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB transmit sequencer feeding the NRZI encoder.
//   clk, n_rst        : clock, asynchronous active-low reset
//   tx_start          : begin a packet (honoured only when idle)
//   tx_data/valid/last: payload byte handshake, consumed when tx_ready
//   tx_ready          : byte taken this cycle if tx_valid (combinational)
//   serial_out        : current bit (1 = hold line, 0 = toggle)
//   bit_strobe        : last clock of each bit period
//   eop               : one-cycle EOP request to the encoder
//   tx_busy           : packet in progress
//   tx_done           : one-cycle pulse when the SE0/SE0/J tail completes
//   tx_error          : one-cycle pulse on payload underrun
module usb_tx_ctrl
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STUFF_LIMIT  = DEFAULT_STUFF_LIMIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       bit_strobe,
    output logic       eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned     OnesW   = $clog2(STUFF_LIMIT + 1);
    localparam logic [OnesW-1:0] OnesMax = OnesW'(STUFF_LIMIT);

    tx_state_t        state_q, pend_q, dest;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx_q;
    logic [OnesW-1:0] ones_cnt_q, ones_inc;
    logic             last_q, serial_q, eop_q;
    logic [1:0]       eop_cnt_q;
    logic             in_byte, byte_end, stuff_now, dest_bit, timer_clear;

    assign tx_busy     = (state_q != StIdle);
    assign timer_clear = !tx_busy;
    assign serial_out  = serial_q;
    assign eop         = eop_q;

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .enable  (tx_busy),
        .clear   (timer_clear),
        .rollover(bit_strobe)
    );

    // dest/dest_bit: where the sequencer goes after this strobe, ignoring stuffing.
    always_comb begin
        in_byte   = (state_q == StSync) || (state_q == StData);
        byte_end  = bit_strobe && in_byte && (bit_idx_q == 3'd7);
        tx_ready  = byte_end && !last_q;
        tx_error  = tx_ready && !tx_valid;
        ones_inc  = ones_cnt_q + OnesW'(1);
        stuff_now = bit_strobe && in_byte && serial_q && (ones_inc == OnesMax);
        tx_done   = (state_q == StEopWait) && bit_strobe && (eop_cnt_q == 2'd2);
        dest      = state_q;
        dest_bit  = shift_q[bit_idx_q + 3'd1];
        if (byte_end) begin
            if (tx_ready && tx_valid) begin
                dest     = StData;
                dest_bit = tx_data[0];
            end else begin
                // Last byte sent, or underrun: go to the tail.
                dest     = StEopWait;
                dest_bit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            pend_q     <= StIdle;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            ones_cnt_q <= '0;
            last_q     <= 1'b0;
            serial_q   <= 1'b1;
            eop_q      <= 1'b0;
            eop_cnt_q  <= '0;
        end else begin
            eop_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_start) begin
                        state_q    <= StSync;
                        shift_q    <= SYNC_BYTE;
                        bit_idx_q  <= '0;
                        ones_cnt_q <= '0;
                        last_q     <= 1'b0;
                        serial_q   <= SYNC_BYTE[0];
                    end
                end
                StSync, StData: begin
                    if (bit_strobe) begin
                        if (byte_end) begin
                            if (tx_ready && tx_valid) begin
                                shift_q   <= tx_data;
                                last_q    <= tx_last;
                                bit_idx_q <= '0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                        eop_cnt_q <= '0;
                        if (stuff_now) begin
                            // bit_idx already points at the bit that follows the stuff.
                            state_q    <= StStuff;
                            pend_q     <= dest;
                            serial_q   <= 1'b0;
                            ones_cnt_q <= '0;
                        end else begin
                            state_q    <= dest;
                            serial_q   <= dest_bit;
                            ones_cnt_q <= serial_q ? ones_inc : '0;
                            eop_q      <= (dest == StEopWait);
                        end
                    end
                end
                StStuff: begin
                    if (bit_strobe) begin
                        state_q    <= pend_q;
                        ones_cnt_q <= '0;
                        eop_cnt_q  <= '0;
                        if (pend_q == StEopWait) begin
                            serial_q <= 1'b1;
                            eop_q    <= 1'b1;
                        end else begin
                            serial_q <= shift_q[bit_idx_q];
                        end
                    end
                end
                StEopWait: begin
                    // Three strobes: SE0, SE0, J.
                    if (bit_strobe) begin
                        if (eop_cnt_q == 2'd2) begin
                            state_q   <= StIdle;
                            eop_cnt_q <= '0;
                        end else begin
                            eop_cnt_q <= eop_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
module tb_usb_tx_ctrl;

    localparam int P     = 8;
    localparam int LIMIT = 6;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start, tx_valid, tx_last;
    logic [7:0] tx_data;
    logic       tx_ready, serial_out, bit_strobe, eop, tx_busy, tx_done, tx_error;

    int checks   = 0;
    int failures = 0;

    // Frame description and reference model results
    logic [7:0] pay[$];
    int         n_valid;
    bit         noise;
    bit         m_bit[$];
    bit         m_req[$];
    bit         m_underrun;
    int         obs_eop, obs_done, obs_err;
    int         obs_ready[$];

    usb_tx_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .serial_out(serial_out),
        .bit_strobe(bit_strobe),
        .eop       (eop),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 clk = ~clk;

    // Bit-period stream: SYNC + supplied bytes LSB-first, then zero-stuffing over the stream.
    task automatic build_model();
        bit         raw[$];
        bit         rreq[$];
        logic [7:0] sb;
        int         cnt;
        m_bit.delete();
        m_req.delete();
        sb = 8'h80;
        for (int i = 0; i < 8; i++) begin
            raw.push_back(sb[i]);
            rreq.push_back(i == 7);
        end
        for (int b = 0; b < n_valid; b++) begin
            sb = pay[b];
            for (int i = 0; i < 8; i++) begin
                raw.push_back(sb[i]);
                rreq.push_back((i == 7) && (b < pay.size() - 1));
            end
        end
        m_underrun = (n_valid < pay.size());
        cnt = 0;
        foreach (raw[k]) begin
            m_bit.push_back(raw[k]);
            m_req.push_back(rreq[k]);
            if (raw[k]) cnt++;
            else cnt = 0;
            if (cnt == LIMIT) begin
                m_bit.push_back(1'b0);
                m_req.push_back(1'b0);
                cnt = 0;
            end
        end
    endtask

    // Runs one frame from its tx_start cycle (cycle 0). Entered and left at posedge+1.
    task automatic run_frame(input int stop_cycle);
        int         n, tend, req, err_p, last_cycle, p;
        logic [6:0] exp_v, got_v;
        logic       e_ser, e_stb, e_rdy, e_err, e_eop, e_busy, e_done;
        build_model();
        n     = m_bit.size();
        tend  = (n + 3) * P;
        err_p = -1;
        if (m_underrun) foreach (m_req[k]) if (m_req[k]) err_p = k;
        obs_eop  = -1;
        obs_done = -1;
        obs_err  = -1;
        obs_ready.delete();
        req = 0;
        last_cycle = (stop_cycle >= 0) ? stop_cycle : tend + 2;
        for (int c = 0; c <= last_cycle; c++) begin
            e_ser = 1'b1; e_stb = 1'b0; e_rdy = 1'b0; e_err = 1'b0;
            e_eop = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (c >= 1 && c <= tend) begin
                e_busy = 1'b1;
                e_stb  = (c % P == 0);
                if (c <= n * P) begin
                    p     = (c - 1) / P;
                    e_ser = m_bit[p];
                    e_rdy = e_stb && m_req[p];
                    e_err = e_rdy && (p == err_p);
                end else begin
                    e_eop  = (c == n * P + 1);
                    e_done = (c == tend);
                end
            end
            tx_start = (c == 0) || (noise && e_busy && ($urandom_range(0, 7) == 0));
            if (noise && !e_rdy) begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom_range(0, 1));
            end else begin
                tx_valid = (req < n_valid);
                tx_data  = (req < pay.size()) ? pay[req] : 8'h00;
                tx_last  = (req == pay.size() - 1);
            end
            @(negedge clk);
            exp_v = {e_ser, e_stb, e_rdy, e_err, e_eop, e_busy, e_done};
            got_v = {serial_out, bit_strobe, tx_ready, tx_error, eop, tx_busy, tx_done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL frame_cycle c=%0d {ser,stb,rdy,err,eop,busy,done} got=%b exp=%b",
                         c, got_v, exp_v);
            end
            if (eop === 1'b1 && obs_eop < 0) obs_eop = c;
            if (tx_done === 1'b1 && obs_done < 0) obs_done = c;
            if (tx_error === 1'b1 && obs_err < 0) obs_err = c;
            if (tx_ready === 1'b1) obs_ready.push_back(c);
            if (e_rdy) req++;
            @(posedge clk);
            #1;
        end
        tx_start = 1'b0;
        tx_valid = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [6:0] got_v;
        got_v = {serial_out, bit_strobe, tx_ready, tx_error, eop, tx_busy, tx_done};
        checks++;
        if (got_v !== 7'b1000000) begin
            failures++;
            $display("FAIL %s {ser,stb,rdy,err,eop,busy,done} got=%b exp=1000000", name, got_v);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; tx_start = 1'b0; tx_valid = 1'b1; tx_last = 1'b0; tx_data = 8'hFF;
        @(negedge clk);
        check_idle_outputs("reset_values");
        @(posedge clk);
        #1;
        n_rst    = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_zero();
        pay.delete(); pay.push_back(8'h00); n_valid = 1; noise = 1'b0;
        run_frame(-1);
        check_int("zero_ready_cycle", (obs_ready.size() > 0) ? obs_ready[0] : -1, 64);
        check_int("zero_eop_cycle", obs_eop, 129);
        check_int("zero_done_cycle", obs_done, 152);
    endtask

    task automatic test_single_ff();
        pay.delete(); pay.push_back(8'hFF); n_valid = 1; noise = 1'b0;
        run_frame(-1);
        check_int("ff_eop_cycle", obs_eop, 137);
        check_int("ff_done_cycle", obs_done, 160);
    endtask

    task automatic test_two_bytes();
        pay.delete(); pay.push_back(8'h3F); pay.push_back(8'hA5); n_valid = 2; noise = 1'b0;
        run_frame(-1);
        // Six ones end exactly at the first byte's bit7: stuff sits between the bytes.
        pay.delete(); pay.push_back(8'hFC); pay.push_back(8'hA5); n_valid = 2; noise = 1'b0;
        run_frame(-1);
        check_int("fc_second_ready", (obs_ready.size() > 1) ? obs_ready[1] : -1, 128);
        check_int("fc_eop_cycle", obs_eop, 201);
        check_int("fc_done_cycle", obs_done, 224);
    endtask

    task automatic test_underrun();
        pay.delete(); pay.push_back(8'h12); n_valid = 0; noise = 1'b0;
        run_frame(-1);
        check_int("underrun_err_cycle", obs_err, 64);
        check_int("underrun_eop_cycle", obs_eop, 65);
        check_int("underrun_done_cycle", obs_done, 88);
    endtask

    task automatic test_start_while_busy();
        pay.delete(); pay.push_back(8'h00); n_valid = 1; noise = 1'b1;
        run_frame(-1);
        check_int("busy_start_eop_cycle", obs_eop, 129);
        check_int("busy_start_done_cycle", obs_done, 152);
    endtask

    task automatic test_reset_mid_packet();
        pay.delete(); pay.push_back(8'h5A); pay.push_back(8'h33); n_valid = 2; noise = 1'b0;
        run_frame(100);
        tx_valid = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid_immediate");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle_outputs("reset_mid_held");
        end
        @(posedge clk);
        #1;
        n_rst    = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        pay.delete(); pay.push_back(8'h00); n_valid = 1; noise = 1'b0;
        run_frame(-1);
        check_int("after_reset_eop_cycle", obs_eop, 129);
    endtask

    task automatic test_random_frames();
        int nb;
        for (int f = 0; f < 8; f++) begin
            nb = $urandom_range(1, 3);
            pay.delete();
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) pay.push_back(8'hFF);
                else pay.push_back(8'($urandom));
            end
            n_valid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : nb;
            noise   = 1'($urandom_range(0, 1));
            run_frame(-1);
        end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_single_ff();
        test_two_bytes();
        test_underrun();
        test_start_while_busy();
        test_reset_mid_packet();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
